alu_mdu_decoder: RTL and testbench

Parametrised next-generation ALU control decoder for the RV32 execute stage. It extends the 3-bit ALU control into a 4-bit encoding that covers the full RV32I set (SLT/SLTU/SRA/LUI pass-through and unsigned branches). It adds a sequencer for the RV32M multi-cycle multiply/divide unit (MDU), which issues start, holds the pipeline with a stall, and signals completion. It sits between the main control decoder and the ALU/MDU datapath.

---
 rtl/alu_mdu_decoder.sv | 144 ++++++++++++++
 tb/tb_alu_mdu_decoder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mdu_decoder.sv
// RV32 execute-stage ALU control decoder with a start/stall/done sequencer
// for the multi-cycle RV32M multiply/divide unit.
//
// state | meaning
// IDLE  | decode only; an accepted MDU request issues start and loads the timer
// BUSY  | MDU running, pipeline stalled, timer counts down to 1
// DONE  | MDU result valid for one cycle, held instruction retires
module alu_mdu_decoder #(
  parameter int CTRL_W   = 4,
  parameter int ENABLE_M = 1,
  parameter int MUL_LAT  = 2,
  parameter int DIV_LAT  = 32,
  parameter int CNT_W    = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic              op_r,
  input  logic [1:0]        alu_op,
  input  logic [2:0]        funct3,
  input  logic              funct7_5,
  input  logic              funct7_0,
  input  logic              flush_i,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              mdu_start,
  output logic [2:0]        mdu_op,
  output logic              mdu_kill,
  output logic              stall_o,
  output logic              done_o,
  output logic              illegal_o
);

  localparam logic [CTRL_W-1:0] C_ADD  = CTRL_W'(0);
  localparam logic [CTRL_W-1:0] C_SUB  = CTRL_W'(1);
  localparam logic [CTRL_W-1:0] C_SLL  = CTRL_W'(2);
  localparam logic [CTRL_W-1:0] C_SLT  = CTRL_W'(3);
  localparam logic [CTRL_W-1:0] C_SLTU = CTRL_W'(4);
  localparam logic [CTRL_W-1:0] C_XOR  = CTRL_W'(5);
  localparam logic [CTRL_W-1:0] C_SRL  = CTRL_W'(6);
  localparam logic [CTRL_W-1:0] C_SRA  = CTRL_W'(7);
  localparam logic [CTRL_W-1:0] C_OR   = CTRL_W'(8);
  localparam logic [CTRL_W-1:0] C_AND  = CTRL_W'(9);
  localparam logic [CTRL_W-1:0] C_PASS = CTRL_W'(10);

  localparam logic             M_EN    = (ENABLE_M != 0);
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             mdu_enc, mdu_req, load;

  assign mdu_enc = (alu_op == 2'b10) & op_r & funct7_0 & ~funct7_5;
  assign mdu_req = valid_i & mdu_enc;

  always_comb begin
    alu_ctrl = C_ADD;
    case (alu_op)
      2'b00: alu_ctrl = C_ADD;
      2'b01: begin
        case (funct3[2:1])
          2'b00:   alu_ctrl = C_SUB;
          2'b01:   alu_ctrl = C_ADD;
          2'b10:   alu_ctrl = C_SLT;
          default: alu_ctrl = C_SLTU;
        endcase
      end
      2'b10: begin
        if (mdu_enc) begin
          alu_ctrl = C_ADD;
        end else begin
          case (funct3)
            3'b000:  alu_ctrl = (op_r & funct7_5) ? C_SUB : C_ADD;
            3'b001:  alu_ctrl = C_SLL;
            3'b010:  alu_ctrl = C_SLT;
            3'b011:  alu_ctrl = C_SLTU;
            3'b100:  alu_ctrl = C_XOR;
            3'b101:  alu_ctrl = funct7_5 ? C_SRA : C_SRL;
            3'b110:  alu_ctrl = C_OR;
            default: alu_ctrl = C_AND;
          endcase
        end
      end
      default: alu_ctrl = C_PASS;
    endcase
  end

  // Branch funct3 010/011 has no RV32I meaning; M ops are illegal when M is absent.
  assign illegal_o = valid_i & (((alu_op == 2'b01) & (funct3[2:1] == 2'b01)) |
                                (~M_EN & mdu_enc));

  // Reset and flush both silence every strobe in the cycle they are seen.
  always_comb begin
    state_nxt = state;
    mdu_start = 1'b0;
    stall_o   = 1'b0;
    done_o    = 1'b0;
    mdu_kill  = 1'b0;
    load      = 1'b0;
    case (state)
      S_IDLE: begin
        if (M_EN & mdu_req & ~flush_i & ~rst) begin
          mdu_start = 1'b1;
          stall_o   = 1'b1;
          load      = 1'b1;
          state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (flush_i) begin
          mdu_kill  = ~rst;
          state_nxt = S_IDLE;
        end else begin
          stall_o = ~rst;
          if (cnt == CNT_W'(1)) state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done_o    = ~flush_i & ~rst;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      mdu_op <= 3'b000;
    end else begin
      state <= state_nxt;
      if (load) begin
        mdu_op <= funct3;
        cnt    <= funct3[2] ? DIV_CNT : MUL_CNT;
      end else if (state == S_BUSY) begin
        cnt <= flush_i ? '0 : cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_mdu_decoder.sv
// Self-checking bench: a timestamp-based model of the MDU sequencer and a
// table-driven decode model, checked every cycle on an M-enabled and an M-disabled DUT.
module tb_alu_mdu_decoder;
  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid_i = 1'b0, op_r = 1'b0, funct7_5 = 1'b0, funct7_0 = 1'b0, flush_i = 1'b0;
  logic [1:0] alu_op = 2'b00;
  logic [2:0] funct3 = 3'b000;

  logic [3:0] alu_ctrl, alu_ctrl_n;
  logic [2:0] mdu_op, mdu_op_n;
  logic mdu_start, mdu_kill, stall_o, done_o, illegal_o;
  logic mdu_start_n, mdu_kill_n, stall_n, done_n, illegal_n;

  alu_mdu_decoder #(.CTRL_W(4), .ENABLE_M(1), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .op_r(op_r), .alu_op(alu_op), .funct3(funct3),
    .funct7_5(funct7_5), .funct7_0(funct7_0), .flush_i(flush_i), .alu_ctrl(alu_ctrl),
    .mdu_start(mdu_start), .mdu_op(mdu_op), .mdu_kill(mdu_kill), .stall_o(stall_o),
    .done_o(done_o), .illegal_o(illegal_o));

  alu_mdu_decoder #(.CTRL_W(4), .ENABLE_M(0), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(6)) dut_nom (
    .clk(clk), .rst(rst), .valid_i(valid_i), .op_r(op_r), .alu_op(alu_op), .funct3(funct3),
    .funct7_5(funct7_5), .funct7_0(funct7_0), .flush_i(flush_i), .alu_ctrl(alu_ctrl_n),
    .mdu_start(mdu_start_n), .mdu_op(mdu_op_n), .mdu_kill(mdu_kill_n), .stall_o(stall_n),
    .done_o(done_n), .illegal_o(illegal_n));

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int exp_ctrl(input logic [1:0] aop, input logic [2:0] f3,
                                  input logic f75, input logic opr, input logic f70);
    int alu_tab[8];
    int br_tab[4];
    alu_tab = '{0, 2, 3, 4, 5, 6, 8, 9};
    br_tab  = '{1, 0, 3, 4};
    case (aop)
      2'd0: return 0;
      2'd1: return br_tab[f3[2:1]];
      2'd2: begin
        if (opr && f70 && !f75) return 0;
        if (f3 == 3'd0) return (opr && f75) ? 1 : 0;
        if (f3 == 3'd5) return f75 ? 7 : 6;
        return alu_tab[f3];
      end
      default: return 10;
    endcase
  endfunction

  // Sequencer model: an accepted op at cycle t0 stalls through t0+lat and completes at t0+lat+1.
  bit         chk_en = 0;
  bit         active = 0;
  int         t = 0, t0 = 0, lat = 0;
  logic [2:0] op_m = 3'b000;

  always @(negedge clk) begin
    bit enc, e_start, e_stall, e_done, e_kill, e_ill_branch;
    int e_ctrl;
    if (chk_en) begin
      enc = (alu_op == 2'd2) && op_r && funct7_0 && !funct7_5;
      e_start = 0; e_stall = 0; e_done = 0; e_kill = 0;
      if (!active) begin
        if (valid_i && enc && !flush_i && !rst) begin e_start = 1; e_stall = 1; end
      end else if (t <= t0 + lat) begin
        if (flush_i) e_kill = !rst;
        else e_stall = !rst;
      end else begin
        e_done = !flush_i && !rst;
      end
      e_ctrl = exp_ctrl(alu_op, funct3, funct7_5, op_r, funct7_0);
      e_ill_branch = valid_i && alu_op == 2'd1 && funct3[2:1] == 2'b01;
      chk("alu_ctrl", 32'(alu_ctrl), 32'(e_ctrl));
      chk("illegal", 32'(illegal_o), 32'(e_ill_branch));
      chk("mdu_start", 32'(mdu_start), 32'(e_start));
      chk("stall", 32'(stall_o), 32'(e_stall));
      chk("done", 32'(done_o), 32'(e_done));
      chk("mdu_kill", 32'(mdu_kill), 32'(e_kill));
      chk("mdu_op", 32'(mdu_op), 32'(op_m));
      chk("nom_alu_ctrl", 32'(alu_ctrl_n), 32'(e_ctrl));
      chk("nom_illegal", 32'(illegal_n), 32'(e_ill_branch || (valid_i && enc)));
      chk("nom_strobes", {28'd0, mdu_start_n, stall_n, done_n, mdu_kill_n}, 32'd0);
      chk("nom_mdu_op", 32'(mdu_op_n), 32'd0);
      if (rst) begin
        active = 0; op_m = 3'b000;
      end else if (!active) begin
        if (e_start) begin
          active = 1; t0 = t; op_m = funct3;
          lat = funct3[2] ? DIV_LAT : MUL_LAT;
        end
      end else if (flush_i || t > t0 + lat) begin
        active = 0;
      end
    end
    t++;
  end

  task automatic set_idle();
    valid_i = 0; alu_op = 2'd0; funct3 = 3'd0; op_r = 0; funct7_5 = 0; funct7_0 = 0;
  endtask

  task automatic set_dec(input logic [1:0] aop, input logic [2:0] f3, input logic f75,
                         input logic opr, input logic f70);
    valid_i = 1; alu_op = aop; funct3 = f3; funct7_5 = f75; op_r = opr; funct7_0 = f70;
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after the op ended.
  task automatic run_mdu(input logic [2:0] f3, input int flush_at, input int rst_at,
                         output int stalls, output int done_at, output int kill_at,
                         output int start_at, output logic [2:0] op1);
    stalls = 0; done_at = -1; kill_at = -1; start_at = -1; op1 = 3'bxxx;
    set_dec(2'd2, f3, 1'b0, 1'b1, 1'b1);
    for (int c = 0; c < 45; c++) begin
      flush_i = (c == flush_at);
      rst     = (c == rst_at);
      #3;
      if (stall_o) stalls++;
      if (done_o && done_at < 0) done_at = c;
      if (mdu_kill && kill_at < 0) kill_at = c;
      if (mdu_start && start_at < 0) start_at = c;
      if (c == 1) op1 = mdu_op;
      @(posedge clk); #1;
      if (done_at >= 0 || kill_at >= 0 || c == rst_at) break;
    end
    flush_i = 0;
    rst = 0;
  endtask

  int st, dn, kl, sa;
  logic [2:0] o1;

  initial begin
    set_idle();
    @(posedge clk); #1;
    chk_en = 1;
    @(posedge clk); #1;
    rst = 0;
    #3;
    chk("reset_outputs", {25'd0, mdu_op, mdu_start, stall_o, done_o, mdu_kill}, 32'd0);

    // Decode sweep with flush held so MDU encodings do not launch an op.
    @(posedge clk); #1;
    flush_i = 1;
    for (int i = 0; i < 128; i++) begin
      set_dec(2'(i >> 5), 3'(i >> 2), i[1], i[0], i[6]);
      @(posedge clk); #1;
    end
    set_dec(2'd2, 3'b101, 1'b1, 1'b1, 1'b0); #2; chk("lit_sra", 32'(alu_ctrl), 32'd7);
    set_dec(2'd1, 3'b110, 1'b0, 1'b0, 1'b0); #2; chk("lit_bltu", 32'(alu_ctrl), 32'd4);
    set_dec(2'd3, 3'b011, 1'b0, 1'b0, 1'b0); #2; chk("lit_lui", 32'(alu_ctrl), 32'd10);
    set_dec(2'd2, 3'b000, 1'b1, 1'b1, 1'b0); #2; chk("lit_sub", 32'(alu_ctrl), 32'd1);
    set_dec(2'd2, 3'b000, 1'b1, 1'b0, 1'b0); #2; chk("lit_addi", 32'(alu_ctrl), 32'd0);
    set_dec(2'd1, 3'b010, 1'b0, 1'b0, 1'b0); #2; chk("lit_br_ill", 32'(illegal_o), 32'd1);
    set_dec(2'd2, 3'b110, 1'b0, 1'b1, 1'b1); #2; chk("lit_rem_ctrl", 32'(alu_ctrl), 32'd0);
    chk("lit_nom_ill", 32'(illegal_n), 32'd1);
    chk("lit_nom_start", {30'd0, mdu_start_n, stall_n}, 32'd0);
    @(posedge clk); #1;
    flush_i = 0;
    set_idle();
    @(posedge clk); #1;

    run_mdu(3'b000, -1, -1, st, dn, kl, sa, o1);
    chk("mul_start", 32'(sa), 32'd0);
    chk("mul_stalls", 32'(st), 32'd3);
    chk("mul_done", 32'(dn), 32'd3);
    chk("mul_op", 32'(o1), 32'd0);
    set_idle(); @(posedge clk); #1;

    run_mdu(3'b100, -1, -1, st, dn, kl, sa, o1);
    chk("div_stalls", 32'(st), 32'd33);
    chk("div_done", 32'(dn), 32'd33);
    chk("div_op", 32'(o1), 32'd4);
    run_mdu(3'b000, -1, -1, st, dn, kl, sa, o1);
    chk("b2b_start", 32'(sa), 32'd0);
    chk("b2b_done", 32'(dn), 32'd3);
    set_idle(); @(posedge clk); #1;

    run_mdu(3'b101, 5, -1, st, dn, kl, sa, o1);
    chk("flush_kill", 32'(kl), 32'd5);
    chk("flush_stalls", 32'(st), 32'd5);
    chk("flush_nodone", 32'(dn), 32'hffffffff);
    run_mdu(3'b001, -1, -1, st, dn, kl, sa, o1);
    chk("post_flush_start", 32'(sa), 32'd0);
    chk("post_flush_done", 32'(dn), 32'd3);
    set_idle(); @(posedge clk); #1;

    run_mdu(3'b011, -1, 2, st, dn, kl, sa, o1);
    set_idle();
    #3;
    chk("rst_clean", {25'd0, mdu_op, mdu_start, stall_o, done_o, mdu_kill}, 32'd0);
    @(posedge clk); #1;
    run_mdu(3'b010, -1, -1, st, dn, kl, sa, o1);
    chk("post_rst_done", 32'(dn), 32'd3);
    chk("post_rst_op", 32'(o1), 32'd2);
    set_idle(); @(posedge clk); #1;

    // Randomized traffic: frequent MDU encodings, occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      valid_i  = ($urandom_range(0, 3) != 0);
      alu_op   = 2'($urandom);
      funct3   = 3'($urandom);
      funct7_5 = 1'($urandom);
      funct7_0 = 1'($urandom);
      op_r     = 1'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        alu_op = 2'd2; op_r = 1; funct7_0 = 1; funct7_5 = 0;
      end
      flush_i = ($urandom_range(0, 19) == 0);
      rst     = ($urandom_range(0, 99) == 0);
      @(posedge clk); #1;
    end
    set_idle(); flush_i = 0; rst = 0;
    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
